// File: rtl/memory_sequence_controller_if.sv
// Player-facing and random-source signals of the memory sequence game,
// bundled so the controller and its surroundings share one connection.
interface memory_sequence_controller_if;
    logic       start;
    logic [2:0] rnd_value;
    logic       lfsr_stop;
    logic       user_valid;
    logic [2:0] user_value;
    logic [2:0] leds;
    logic [4:0] level;
    logic       round_ok;
    logic       fail;
    logic       win;

    modport master (
        output start, rnd_value, user_valid, user_value,
        input  lfsr_stop, leds, level, round_ok, fail, win
    );

    modport slave (
        input  start, rnd_value, user_valid, user_value,
        output lfsr_stop, leds, level, round_ok, fail, win
    );
endinterface

// File: rtl/memory_sequence_controller.sv
// Memory game sequencer: grows a random sequence by one entry per round,
// plays it back on the LEDs, then checks the player's entries against it.
module memory_sequence_controller #(
    parameter int MAX_LEN     = 8,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    memory_sequence_controller_if.slave   bus
);

    localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << IW;
    localparam int CW    = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SHOW, S_GAP, S_INPUT, S_ROUND_OK, S_FAIL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      level_q, level_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            mem_we;
    logic [2:0]      seq_mem [DEPTH];
    logic [2:0]      cur_value;
    logic            at_last;

    assign cur_value = seq_mem[idx_q];
    assign at_last   = ({{(5-IW){1'b0}}, idx_q} == (level_q - 5'd1));
    assign bus.level = level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Entries beyond level are never read, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            seq_mem[level_q[IW-1:0]] <= bus.rnd_value;
        end
    end

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        mem_we        = 1'b0;
        bus.leds      = 3'b000;
        bus.lfsr_stop = 1'b0;
        bus.round_ok  = 1'b0;
        bus.fail      = 1'b0;
        bus.win       = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL, S_DONE: begin
                bus.fail      = (state_q == S_FAIL);
                bus.win       = (state_q == S_DONE);
                bus.lfsr_stop = (state_q != S_IDLE);
                if (bus.start) begin
                    level_d = '0;
                    idx_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                mem_we  = 1'b1;
                level_d = level_q + 5'd1;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                bus.leds      = cur_value;
                bus.lfsr_stop = 1'b1;
                if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                bus.lfsr_stop = 1'b1;
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INPUT: begin
                if (bus.user_valid) begin
                    if (bus.user_value != cur_value) begin
                        state_d = S_FAIL;
                    end else if (at_last) begin
                        state_d = S_ROUND_OK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_ROUND_OK: begin
                bus.round_ok  = 1'b1;
                bus.lfsr_stop = 1'b1;
                state_d       = (level_q == 5'(MAX_LEN)) ? S_DONE : S_CAPTURE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
